// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle between the report formatter and the UART transmitter.
// The transmitter takes the slave side; the producer of bytes takes the master side.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, even parity, stop bit.
// Every bit lasts CLKS_PER_BIT cycles of clk_3125; all outputs come straight from flops.
module uart_tx #(
    parameter int CLKS_PER_BIT = 14,
    parameter int DATA_BITS    = 8
) (
    input  logic     clk_3125,
    input  logic     rst_n,
    uart_tx_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DONE_AT  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 parity;
    logic                 accept;
    logic                 bit_end;

    // tx_done is high only in the last stop-bit cycle, which is how back-to-back frames chain.
    assign accept  = bus.tx_start && ((state == IDLE) || bus.tx_done);
    assign bit_end = (bit_cnt == CNT_LAST);

    // NOTE: non-blocking assignments everywhere here, so every decision uses pre-edge register values.
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            parity      <= 1'b0;
            bus.tx      <= 1'b1;
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b0;
        end else begin
            bus.tx_done <= 1'b0;
            if (accept) begin
                state       <= START;
                bit_cnt     <= '0;
                bit_idx     <= '0;
                shift       <= bus.tx_data;
                parity      <= ^bus.tx_data;
                bus.tx      <= 1'b0;
                bus.tx_busy <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        bus.tx      <= 1'b1;
                        bus.tx_busy <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            bus.tx  <= shift[0];
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            bit_cnt <= '0;
                            if (bit_idx == IDX_LAST) begin
                                state  <= PARITY;
                                bus.tx <= parity;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                shift   <= shift >> 1;
                                bus.tx  <= shift[1];
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                            bus.tx  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            state       <= IDLE;
                            bit_cnt     <= '0;
                            bus.tx      <= 1'b1;
                            bus.tx_busy <= 1'b0;
                        end else begin
                            bit_cnt     <= bit_cnt + 1'b1;
                            bus.tx_done <= (bit_cnt == DONE_AT);
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        bit_cnt     <= '0;
                        bus.tx      <= 1'b1;
                        bus.tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle line capture, bench-side frame decode,
// and a byte scoreboard filled at request time and drained as frames are decoded.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int CPB   = 14;
    localparam int FRAME = 154;

    logic clk_3125 = 1'b0;
    logic rst_n    = 1'b0;
    always #160 clk_3125 = ~clk_3125;

    uart_tx_if #(.DATA_BITS(8)) bus ();

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) u_dut (
        .clk_3125 (clk_3125),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];
    logic       tx_s   [1:400];
    logic       busy_s [1:400];
    logic       done_s [1:400];

    // Expected 11-bit frame, index 0 is the first bit on the wire.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    function automatic logic [10:0] sample_frame(input int k0);
        logic [10:0] f;
        for (int b = 0; b < 11; b++) f[b] = tx_s[k0 + CPB*b + CPB/2];
        return f;
    endfunction

    function automatic int count_high_done(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (done_s[k] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_busy(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (busy_s[k] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_tx_low(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (tx_s[k] !== 1'b1) n++;
        return n;
    endfunction

    // Requests a byte while the DUT is idle; returns just after the accepting edge.
    task automatic request(input logic [7:0] d);
        @(negedge clk_3125);
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        sb.push_back(d);
        @(posedge clk_3125);
        #1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    // Sample cycles 1..n after the accepting edge, mid-cycle.
    task automatic capture(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_3125);
            tx_s[k]   = bus.tx;
            busy_s[k] = bus.tx_busy;
            done_s[k] = bus.tx_done;
        end
    endtask

    task automatic test_reset();
        int bad;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk_3125);
        n_checks++;
        if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        n_checks++;
        if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.tx_busy); end
        n_checks++;
        if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.tx_done); end
        rst_n = 1'b1;
        capture(20);
        bad = count_tx_low(1, 20) + count_busy(1, 20) + count_high_done(1, 20);
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL idle_after_reset: %0d non-idle samples, want 0", bad); end
    endtask

    task automatic test_frame_a();
        logic [7:0]  exp_d;
        logic [10:0] ef;
        int          bad;
        request(8'h41);
        capture(160);
        exp_d = sb.pop_front();
        ef    = frame_of(exp_d);
        for (int b = 0; b < 11; b++) begin
            bad = 0;
            for (int c = 0; c < CPB; c++) if (tx_s[1 + CPB*b + c] !== ef[b]) bad++;
            n_checks++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL frame_a_bit%0d: %0d of 14 cycles differ from %b", b, bad, ef[b]);
            end
        end
        n_checks++;
        if (done_s[FRAME] !== 1'b1) begin n_fail++; $display("FAIL frame_a_done154: got %b want 1", done_s[FRAME]); end
        n_checks++;
        if (count_high_done(1, 160) !== 1) begin
            n_fail++; $display("FAIL frame_a_done_count: got %0d want 1", count_high_done(1, 160));
        end
        n_checks++;
        if (count_busy(1, FRAME) !== FRAME) begin
            n_fail++; $display("FAIL frame_a_busy: got %0d busy cycles want %0d", count_busy(1, FRAME), FRAME);
        end
        n_checks++;
        if (busy_s[FRAME+1] !== 1'b0) begin n_fail++; $display("FAIL frame_a_busy155: got %b want 0", busy_s[FRAME+1]); end
        n_checks++;
        if (count_tx_low(FRAME+1, 160) !== 0) begin n_fail++; $display("FAIL frame_a_idle_line: line not high after frame"); end
    endtask

    task automatic test_parity();
        logic [7:0]  vec_d [2] = '{8'h37, 8'h00};
        logic        vec_p [2] = '{1'b1, 1'b0};
        logic [7:0]  exp_d;
        logic [10:0] got;
        for (int i = 0; i < 2; i++) begin
            request(vec_d[i]);
            capture(FRAME + 2);
            exp_d = sb.pop_front();
            got   = sample_frame(1);
            n_checks++;
            if (got[9] !== vec_p[i]) begin
                n_fail++; $display("FAIL parity_%h: got %b want %b", vec_d[i], got[9], vec_p[i]);
            end
            n_checks++;
            if (got !== frame_of(exp_d)) begin
                n_fail++; $display("FAIL frame_%h: got %b want %b", vec_d[i], got, frame_of(exp_d));
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0]  msg [3] = '{8'h52, 8'h47, 8'h42};
        logic [7:0]  exp_d;
        logic [10:0] got;
        for (int i = 0; i < 3; i++) begin
            request(msg[i]);
            capture(FRAME + 4);
            exp_d = sb.pop_front();
            got   = sample_frame(1);
            n_checks++;
            if (got[8:1] !== exp_d || got[0] !== 1'b0 || got[10] !== 1'b1) begin
                n_fail++; $display("FAIL loopback_byte%0d: got %h (frame %b) want %h", i, got[8:1], got, exp_d);
            end
            n_checks++;
            if (got[9] !== ^exp_d) begin
                n_fail++; $display("FAIL loopback_parity%0d: got %b want %b", i, got[9], ^exp_d);
            end
            n_checks++;
            if (count_high_done(1, FRAME + 4) !== 1) begin
                n_fail++; $display("FAIL loopback_done%0d: got %0d pulses want 1", i, count_high_done(1, FRAME + 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] got;
        logic [7:0]  exp_d;
        @(negedge clk_3125);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h55;
        sb.push_back(8'h55);
        @(posedge clk_3125);
        #1;
        bus.tx_data = 8'hAA;
        sb.push_back(8'hAA);
        fork
            capture(2*FRAME + 4);
            begin
                repeat (FRAME) @(posedge clk_3125);
                #1;
                bus.tx_start = 1'b0;
            end
        join
        n_checks++;
        if (count_busy(1, 2*FRAME) !== 2*FRAME) begin
            n_fail++; $display("FAIL b2b_busy: got %0d busy cycles want %0d", count_busy(1, 2*FRAME), 2*FRAME);
        end
        n_checks++;
        if (busy_s[2*FRAME+1] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy309: got %b want 0", busy_s[2*FRAME+1]); end
        n_checks++;
        if (tx_s[FRAME+1] !== 1'b0) begin n_fail++; $display("FAIL b2b_start155: got %b want 0", tx_s[FRAME+1]); end
        n_checks++;
        if (done_s[FRAME] !== 1'b1 || done_s[2*FRAME] !== 1'b1 || count_high_done(1, 2*FRAME + 4) !== 2) begin
            n_fail++; $display("FAIL b2b_done: got %0d pulses (154=%b 308=%b) want 2", count_high_done(1, 2*FRAME + 4),
                               done_s[FRAME], done_s[2*FRAME]);
        end
        for (int f = 0; f < 2; f++) begin
            exp_d = sb.pop_front();
            got   = sample_frame(1 + f*FRAME);
            n_checks++;
            if (got !== frame_of(exp_d)) begin
                n_fail++; $display("FAIL b2b_frame%0d: got %b want %b", f, got, frame_of(exp_d));
            end
        end
        n_checks++;
        if (count_tx_low(2*FRAME + 1, 2*FRAME + 4) !== 0) begin n_fail++; $display("FAIL b2b_idle_line: line not high"); end
    endtask

    task automatic test_ignore();
        logic [7:0]  exp_d;
        logic [10:0] got;
        request(8'h41);
        fork
            capture(170);
            begin
                repeat (39) @(posedge clk_3125);
                #1;
                bus.tx_start = 1'b1;
                bus.tx_data  = 8'h33;
                @(posedge clk_3125);
                #1;
                bus.tx_start = 1'b0;
            end
        join
        exp_d = sb.pop_front();
        got   = sample_frame(1);
        n_checks++;
        if (got !== frame_of(exp_d)) begin n_fail++; $display("FAIL ignore_frame: got %b want %b", got, frame_of(exp_d)); end
        n_checks++;
        if (count_high_done(1, 170) !== 1) begin
            n_fail++; $display("FAIL ignore_done: got %0d pulses want 1", count_high_done(1, 170));
        end
        n_checks++;
        if (count_busy(FRAME + 1, 170) !== 0 || count_tx_low(FRAME + 1, 170) !== 0) begin
            n_fail++; $display("FAIL ignore_second_frame: busy %0d low %0d after frame, want 0 0",
                               count_busy(FRAME + 1, 170), count_tx_low(FRAME + 1, 170));
        end
    endtask

    task automatic test_midframe_reset();
        logic [7:0]  exp_d;
        logic [7:0]  dropped;
        logic [10:0] got;
        int          bad;
        request(8'hC3);
        repeat (69) @(posedge clk_3125);
        #1;
        rst_n = 1'b0;
        dropped = sb.pop_front();
        #1;
        n_checks++;
        if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
            n_fail++; $display("FAIL midreset_async: tx=%b busy=%b done=%b want 1 0 0 (byte %h)",
                               bus.tx, bus.tx_busy, bus.tx_done, dropped);
        end
        repeat (3) @(negedge clk_3125);
        rst_n = 1'b1;
        capture(200);
        bad = count_tx_low(1, 200) + count_busy(1, 200) + count_high_done(1, 200);
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL midreset_idle: %0d non-idle samples, want 0", bad); end
        request(8'h96);
        capture(FRAME + 2);
        exp_d = sb.pop_front();
        got   = sample_frame(1);
        n_checks++;
        if (got !== frame_of(exp_d)) begin n_fail++; $display("FAIL midreset_recover: got %b want %b", got, frame_of(exp_d)); end
    endtask

    initial begin
        #(64'd50000 * 64'd320);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        test_reset();
        test_frame_a();
        test_parity();
        test_loopback();
        test_back_to_back();
        test_ignore();
        test_midframe_reset();
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_empty: %0d bytes left, want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
